// File: rtl/regfile_alu_if.sv
// Bundles the instruction-side controls, the external input and the
// register outputs of regfile_alu into one interface. The control unit
// (or a testbench) uses the master view; the datapath uses the slave view.
interface regfile_alu_if;
  logic [3:0] sel_y;
  logic [3:0] imm;
  logic [3:0] ld;
  logic       ld_pc_cond;
  logic       stall;
  logic [3:0] in_port;
  logic [3:0] reg_a;
  logic [3:0] reg_b;
  logic [3:0] in_sync;
  logic [3:0] out_port;
  logic [3:0] pc;
  logic       carry;

  modport master (
    output sel_y, imm, ld, ld_pc_cond, stall, in_port,
    input  reg_a, reg_b, in_sync, out_port, pc, carry
  );

  modport slave (
    input  sel_y, imm, ld, ld_pc_cond, stall, in_port,
    output reg_a, reg_b, in_sync, out_port, pc, carry
  );
endinterface

// File: rtl/regfile_alu.sv
// Register file plus 4-bit adder of a tiny accumulator CPU. Each executed
// cycle adds the selector operand to the immediate, writes the sum into
// the registers chosen by ld, updates carry and advances or loads the PC.
// Every output comes straight from a flop, so there is no input-to-output
// combinational path and any feedback through the selector goes via the
// registers only.
module regfile_alu (
  input  logic           clk,
  input  logic           rst_n,
  regfile_alu_if.slave   bus
);

  logic [3:0] reg_a_q;
  logic [3:0] reg_b_q;
  logic [3:0] out_q;
  logic [3:0] pc_q;
  logic       carry_q;
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;

  logic [4:0] sum;
  logic [3:0] result;
  logic       cout;
  logic       pc_take;

  // Adder and jump decision; the jnc test uses the carry held before this edge.
  always_comb begin
    sum     = {1'b0, bus.sel_y} + {1'b0, bus.imm};
    result  = sum[3:0];
    cout    = sum[4];
    pc_take = bus.ld[3] && (!bus.ld_pc_cond || !carry_q);
  end

  // Architectural state: frozen while stalled, otherwise one instruction per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a_q <= 4'h0;
      reg_b_q <= 4'h0;
      out_q   <= 4'h0;
      pc_q    <= 4'h0;
      carry_q <= 1'b0;
    end else if (!bus.stall) begin
      if (bus.ld[0]) reg_a_q <= result;
      if (bus.ld[1]) reg_b_q <= result;
      if (bus.ld[2]) out_q   <= result;
      carry_q <= cout;
      pc_q    <= pc_take ? result : pc_q + 4'd1;
    end
  end

  // Two-flop synchroniser for the external input; runs even during stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'h0;
      sync2_q <= 4'h0;
    end else begin
      sync1_q <= bus.in_port;
      sync2_q <= sync1_q;
    end
  end

  assign bus.reg_a    = reg_a_q;
  assign bus.reg_b    = reg_b_q;
  assign bus.out_port = out_q;
  assign bus.pc       = pc_q;
  assign bus.carry    = carry_q;
  assign bus.in_sync  = sync2_q;

endmodule

// File: tb/tb_regfile_alu.sv
// Directed testbench for regfile_alu: a linear sequence of hand-computed
// instruction steps, each result checked with an immediate assertion.
module tb_regfile_alu;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  regfile_alu_if bus ();

  regfile_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one instruction, clock it in and settle 1 time unit past the edge.
  task automatic applyStimulus(input logic [3:0] sel_y, input logic [3:0] imm,
                               input logic [3:0] ld, input logic cond,
                               input logic stall);
    bus.sel_y      = sel_y;
    bus.imm        = imm;
    bus.ld         = ld;
    bus.ld_pc_cond = cond;
    bus.stall      = stall;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.sel_y = 4'h0; bus.imm = 4'h0; bus.ld = 4'h0;
    bus.ld_pc_cond = 1'b0; bus.stall = 1'b0; bus.in_port = 4'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_reg_a",   {4'h0, bus.reg_a},    8'h00);
    checkOutput("rst_reg_b",   {4'h0, bus.reg_b},    8'h00);
    checkOutput("rst_out",     {4'h0, bus.out_port}, 8'h00);
    checkOutput("rst_pc",      {4'h0, bus.pc},       8'h00);
    checkOutput("rst_carry",   {7'h0, bus.carry},    8'h00);
    checkOutput("rst_in_sync", {4'h0, bus.in_sync},  8'h00);
    rst_n = 1'b1;

    // Add with carry: C+7 = 0x13
    applyStimulus(4'hC, 4'h7, 4'b0001, 1'b0, 1'b0);
    checkOutput("add_reg_a", {4'h0, bus.reg_a}, 8'h03);
    checkOutput("add_carry", {7'h0, bus.carry}, 8'h01);
    checkOutput("add_pc",    {4'h0, bus.pc},    8'h01);
    checkOutput("add_reg_b", {4'h0, bus.reg_b}, 8'h00);

    // jnc not taken (carry=1): pc 1->2, carry cleared by 0+A
    applyStimulus(4'h0, 4'hA, 4'b1000, 1'b1, 1'b0);
    checkOutput("jnc_nt_pc",    {4'h0, bus.pc},    8'h02);
    checkOutput("jnc_nt_carry", {7'h0, bus.carry}, 8'h00);
    checkOutput("jnc_nt_reg_a", {4'h0, bus.reg_a}, 8'h03);

    // jnc taken (carry=0): pc=A
    applyStimulus(4'h0, 4'hA, 4'b1000, 1'b1, 1'b0);
    checkOutput("jnc_t_pc",    {4'h0, bus.pc},    8'h0A);
    checkOutput("jnc_t_carry", {7'h0, bus.carry}, 8'h00);

    // Multi-load: 2+1 into A, B, OUT
    applyStimulus(4'h2, 4'h1, 4'b0111, 1'b0, 1'b0);
    checkOutput("ml_reg_a", {4'h0, bus.reg_a},    8'h03);
    checkOutput("ml_reg_b", {4'h0, bus.reg_b},    8'h03);
    checkOutput("ml_out",   {4'h0, bus.out_port}, 8'h03);
    checkOutput("ml_carry", {7'h0, bus.carry},    8'h00);
    checkOutput("ml_pc",    {4'h0, bus.pc},       8'h0B);

    // Unconditional jump F+F = 0x1E: pc=E, carry=1
    applyStimulus(4'hF, 4'hF, 4'b1000, 1'b0, 1'b0);
    checkOutput("jmp_pc",    {4'h0, bus.pc},    8'h0E);
    checkOutput("jmp_carry", {7'h0, bus.carry}, 8'h01);

    // No loads, F+1 = 0x10: pc=F, carry=1, registers untouched
    applyStimulus(4'hF, 4'h1, 4'b0000, 1'b0, 1'b0);
    checkOutput("nold_pc",    {4'h0, bus.pc},       8'h0F);
    checkOutput("nold_carry", {7'h0, bus.carry},    8'h01);
    checkOutput("nold_out",   {4'h0, bus.out_port}, 8'h03);

    // Stall 3 cycles with loads requested; synchroniser keeps running
    bus.in_port = 4'h5;
    applyStimulus(4'h5, 4'h5, 4'b1111, 1'b1, 1'b1);
    checkOutput("st1_pc",      {4'h0, bus.pc},      8'h0F);
    checkOutput("st1_in_sync", {4'h0, bus.in_sync}, 8'h00);
    applyStimulus(4'h5, 4'h5, 4'b1111, 1'b1, 1'b1);
    checkOutput("st2_in_sync", {4'h0, bus.in_sync}, 8'h05);
    checkOutput("st2_reg_a",   {4'h0, bus.reg_a},   8'h03);
    applyStimulus(4'h5, 4'h5, 4'b1111, 1'b1, 1'b1);
    checkOutput("st3_pc",    {4'h0, bus.pc},       8'h0F);
    checkOutput("st3_carry", {7'h0, bus.carry},    8'h01);
    checkOutput("st3_reg_b", {4'h0, bus.reg_b},    8'h03);
    checkOutput("st3_out",   {4'h0, bus.out_port}, 8'h03);

    // Resume with no loads: pc wraps F->0, carry cleared
    applyStimulus(4'h0, 4'h0, 4'b0000, 1'b0, 1'b0);
    checkOutput("wrap_pc",    {4'h0, bus.pc},    8'h00);
    checkOutput("wrap_carry", {7'h0, bus.carry}, 8'h00);

    // Jump F+A = 0x19 with A load: pc=9, carry=1, reg_a=9
    applyStimulus(4'hF, 4'hA, 4'b1001, 1'b0, 1'b0);
    checkOutput("pre_pc",    {4'h0, bus.pc},    8'h09);
    checkOutput("pre_carry", {7'h0, bus.carry}, 8'h01);
    checkOutput("pre_reg_a", {4'h0, bus.reg_a}, 8'h09);

    // Asynchronous reset mid-cycle with a write still pending
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_pc",      {4'h0, bus.pc},       8'h00);
    checkOutput("ar_carry",   {7'h0, bus.carry},    8'h00);
    checkOutput("ar_reg_a",   {4'h0, bus.reg_a},    8'h00);
    checkOutput("ar_reg_b",   {4'h0, bus.reg_b},    8'h00);
    checkOutput("ar_out",     {4'h0, bus.out_port}, 8'h00);
    checkOutput("ar_in_sync", {4'h0, bus.in_sync},  8'h00);
    #2;
    rst_n = 1'b1;

    // First instruction after reset starts from all-zero state
    applyStimulus(4'h1, 4'h2, 4'b0001, 1'b0, 1'b0);
    checkOutput("post_reg_a",   {4'h0, bus.reg_a},   8'h03);
    checkOutput("post_pc",      {4'h0, bus.pc},      8'h01);
    checkOutput("post_in_sync", {4'h0, bus.in_sync}, 8'h00);
    applyStimulus(4'h0, 4'h0, 4'b0000, 1'b0, 1'b0);
    checkOutput("post2_in_sync", {4'h0, bus.in_sync}, 8'h05);
    checkOutput("post2_pc",      {4'h0, bus.pc},      8'h02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/regfile_alu.md
REGFILE_ALU -- requirements
Module: regfile_alu

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port sel_y, input, 4 bits: operand from the upstream data selector output.
REQ-004 SHALL have port imm, input, 4 bits: immediate field of the current instruction.
REQ-005 SHALL have port ld, input, 4 bits: write enables; bit0 = A, bit1 = B, bit2 = OUT, bit3 = PC.
REQ-006 SHALL have port ld_pc_cond, input, 1 bit: when 1, the PC load is conditional on carry = 0 (jnc).
REQ-007 SHALL have port stall, input, 1 bit: when 1, the current cycle executes no instruction.
REQ-008 SHALL have port in_port, input, 4 bits: asynchronous external input.
REQ-009 SHALL have port reg_a, output, 4 bits: register A; feeds selector input c0.
REQ-010 SHALL have port reg_b, output, 4 bits: register B; feeds selector input c1.
REQ-011 SHALL have port in_sync, output, 4 bits: synchronised in_port; feeds selector input c2.
REQ-012 SHALL have port out_port, output, 4 bits: output register.
REQ-013 SHALL have port pc, output, 4 bits: program counter.
REQ-014 SHALL have port carry, output, 1 bit: carry flag register.

Function
REQ-015 SHALL compute a 5-bit combinational sum = {0,sel_y} + {0,imm}; result = sum[3:0], cout = sum[4].
REQ-016 SHALL, on an executed cycle (stall=0), load result into each register whose ld bit is set; multiple bits set in the same cycle SHALL all load the same result.
REQ-017 SHALL leave every register whose ld bit is clear unchanged.
REQ-018 SHALL, on an executed cycle, update carry to cout on every instruction, regardless of ld.
REQ-019 SHALL define the PC take condition as ld[3] and (ld_pc_cond=0 or carry=0), using the carry value before this edge's update.
REQ-020 SHALL, on an executed cycle, set pc to result when the take condition holds, else to pc+1 mod 16 (15 wraps to 0).
REQ-021 SHALL, on a stalled cycle (stall=1), hold A, B, OUT, PC and carry, ignoring ld and ld_pc_cond.
REQ-022 SHALL synchronise in_port through a two-flop chain that advances every cycle, independent of stall; in_sync is the second flop, giving 2-cycle latency.
REQ-023 SHALL drive every output directly from a register, with no combinational path from any input to any output.
REQ-024 SHALL produce latency 1: register writes become visible on the outputs on the edge following the instruction.
REQ-025 SHALL NOT feed result back combinationally into sel_y; any feedback loop is closed only through the registers.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force reg_a, reg_b, out_port, pc, carry and both sync flops to 0.
REQ-027 SHALL, on a reset asserted mid-operation, clear all state immediately and discard any in-flight write.
REQ-028 SHALL make the first executed edge after rst_n rises behave as an ordinary instruction from all-zero state.

Verification
REQ-029 SHALL be checked for reset: drive rst_n=0 asynchronously mid-cycle with pc=9, carry=1 -> all outputs read 0 before the next clock edge.
REQ-030 SHALL be checked for add with carry: sel_y=0xC, imm=0x7, ld=0001 -> next cycle reg_a=0x3, carry=1, pc incremented by 1.
REQ-031 SHALL be checked for a taken jnc: carry=0, sel_y=0, imm=0xA, ld=1000, ld_pc_cond=1 -> pc=0xA.
REQ-032 SHALL be checked for a not-taken jnc: same stimulus as REQ-031 but with carry=1 -> pc = old pc + 1, and carry updates to 0.
REQ-033 SHALL be checked for stall and PC wrap: pc=0xF with stall=1 for 3 cycles -> pc, carry and registers hold; in_port=0x5 appears on in_sync after 2 cycles; then stall=0 with ld=0 -> pc=0x0.
REQ-034 SHALL be checked for a multi-load: ld=0111, sel_y=0x2, imm=0x1 -> reg_a = reg_b = out_port = 0x3, carry=0.
